// File: rtl/bcd_countdown70.sv
// -----------------------------------------------------------------------------
// bcd_countdown70
//   Two-digit BCD countdown timer (units 0..UNITS_MAX, tens 0..TENS_MAX).
//   The count is loaded with a clamped start value and decremented once per
//   qualified tick while running. When it reaches 00 the timer expires and
//   pulses done. With AUTO_RELOAD set, expiry instead reloads the last
//   loaded value and the timer keeps running.
//   The units-to-tens borrow is an ordinary same-clock condition inside the
//   next-state logic. No derived clock is used.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high, highest priority
//   load        capture load_units / load_tens (clamped), go to IDLE
//   load_units  units load value (BCD, clamped to UNITS_MAX)
//   load_tens   tens load value (clamped to TENS_MAX)
//   start       begin counting from IDLE, or resume from PAUSE
//   pause       suspend counting; wins over start
//   tick        decrement qualifier while running
//   Q1          units digit
//   Q2          tens digit
//   busy        registered, high while the state is RUN
//   done        registered one-cycle pulse, high exactly when expiry shows
// -----------------------------------------------------------------------------
module bcd_countdown70 #(
  parameter int UNITS_MAX   = 9,
  parameter int TENS_MAX    = 6,
  parameter int AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_units,
  input  logic [2:0] load_tens,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] Q1,
  output logic [2:0] Q2,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] q1_q, q1_d;
  logic [2:0] q2_q, q2_d;
  logic [3:0] rl1_q, rl1_d;
  logic [2:0] rl2_q, rl2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       at_zero;
  logic       last_tick;
  logic       reload_nz;
  logic [3:0] units_clamped;
  logic [2:0] tens_clamped;

  function automatic logic [3:0] clamp_units(input logic [3:0] v);
    return (v > 4'(UNITS_MAX)) ? 4'(UNITS_MAX) : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > 3'(TENS_MAX)) ? 3'(TENS_MAX) : v;
  endfunction

  assign units_clamped = clamp_units(load_units);
  assign tens_clamped  = clamp_tens(load_tens);

  assign at_zero   = (q1_q == 4'd0) && (q2_q == 3'd0);
  // Count is 01: the tick taken now is the expiring one.
  assign last_tick = (q1_q == 4'd1) && (q2_q == 3'd0);
  // A reload value of 00 would re-expire forever, so treat it as no reload.
  assign reload_nz = (rl1_q != 4'd0) || (rl2_q != 3'd0);

  always_comb begin
    state_d = state_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    rl1_d   = rl1_q;
    rl2_d   = rl2_q;
    done_d  = 1'b0;

    if (load) begin
      q1_d    = units_clamped;
      q2_d    = tens_clamped;
      rl1_d   = units_clamped;
      rl2_d   = tens_clamped;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!pause && start && !at_zero) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick && !at_zero) begin
            if (last_tick) begin
              done_d = 1'b1;
              if ((AUTO_RELOAD != 0) && reload_nz) begin
                q1_d = rl1_q;
                q2_d = rl2_q;
              end else begin
                q1_d    = 4'd0;
                q2_d    = 3'd0;
                state_d = S_EXPIRED;
              end
            end else if (q1_q != 4'd0) begin
              q1_d = q1_q - 4'd1;
            end else begin
              // Borrow from tens: units wrap to their maximum.
              q1_d = 4'(UNITS_MAX);
              q2_d = q2_q - 3'd1;
            end
          end
        end
        S_PAUSE: begin
          if (!pause && start) state_d = S_RUN;
        end
        S_EXPIRED: begin
          state_d = S_EXPIRED;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q1_q    <= 4'd0;
      q2_q    <= 3'd0;
      rl1_q   <= 4'd0;
      rl2_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      rl1_q   <= rl1_d;
      rl2_q   <= rl2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q1   = q1_q;
  assign Q2   = q2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_countdown70.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown70
//   Drives two instances side by side from the same inputs: one with
//   AUTO_RELOAD=0 (a_*) and one with AUTO_RELOAD=1 (b_*). A reference model
//   holds each count as a plain integer 0..69 and derives the digits by
//   division, so borrows fall out of ordinary arithmetic.
// -----------------------------------------------------------------------------
module tb_bcd_countdown70;

  localparam int UM = 9;
  localparam int TM = 6;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, tick;
  logic [3:0] lu;
  logic [2:0] lt;
  logic [3:0] a_q1, b_q1;
  logic [2:0] a_q2, b_q2;
  logic       a_busy, a_done, b_busy, b_done;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_cnt [2];
  int m_st  [2];
  int m_rl  [2];
  bit m_done[2];

  always #5 clk = ~clk;

  bcd_countdown70 #(.UNITS_MAX(9), .TENS_MAX(6), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_units(lu), .load_tens(lt),
    .start(start), .pause(pause), .tick(tick),
    .Q1(a_q1), .Q2(a_q2), .busy(a_busy), .done(a_done)
  );

  bcd_countdown70 #(.UNITS_MAX(9), .TENS_MAX(6), .AUTO_RELOAD(1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_units(lu), .load_tens(lt),
    .start(start), .pause(pause), .tick(tick),
    .Q1(b_q1), .Q2(b_q2), .busy(b_busy), .done(b_done)
  );

  function automatic void model_step(input bit r, ld, input int u, t,
                                     input bit s, p, k);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (r) begin
        m_cnt[i] = 0; m_st[i] = M_IDLE; m_rl[i] = 0;
      end else if (ld) begin
        m_cnt[i] = ((t > TM) ? TM : t) * 10 + ((u > UM) ? UM : u);
        m_rl[i]  = m_cnt[i];
        m_st[i]  = M_IDLE;
      end else begin
        case (m_st[i])
          M_IDLE:  if (!p && s && m_cnt[i] != 0) m_st[i] = M_RUN;
          M_RUN: begin
            if (p) m_st[i] = M_PAUSE;
            else if (k && m_cnt[i] > 0) begin
              m_cnt[i] = m_cnt[i] - 1;
              if (m_cnt[i] == 0) begin
                m_done[i] = 1'b1;
                if (i == 1 && m_rl[i] != 0) m_cnt[i] = m_rl[i];
                else m_st[i] = M_EXP;
              end
            end
          end
          M_PAUSE: if (!p && s) m_st[i] = M_RUN;
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [17:0] obs();
    return {a_q2, a_q1, a_busy, a_done, b_q2, b_q1, b_busy, b_done};
  endfunction

  function automatic logic [17:0] expv();
    logic [17:0] v;
    for (int i = 0; i < 2; i++)
      v[17 - 9*i -: 9] = {3'(m_cnt[i] / 10), 4'(m_cnt[i] % 10),
                          m_st[i] == M_RUN, m_done[i]};
    return v;
  endfunction

  task automatic drive(input bit r, ld, input int u, t, input bit s, p, k);
    rst = r; load = ld; lu = 4'(u); lt = 3'(t); start = s; pause = p; tick = k;
    @(posedge clk);
    model_step(r, ld, u, t, s, p, k);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 1, 0, 1);
    n_cmp++;
    if (obs() !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), 18'd0);
    end
    drive(1, 1, 4, 2, 0, 0, 0);
    n_cmp++;
    if (obs() !== 18'd0) begin
      n_fail++; $display("FAIL reset_over_load: got %h expected %h", obs(), 18'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_countdown();
    int e;
    drive(0, 1, 3, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({a_q2, a_q1, a_busy, a_done} !== {3'd1, 4'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL countdown_start: got %h expected %h",
                         {a_q2, a_q1, a_busy, a_done}, {3'd1, 4'd3, 1'b1, 1'b0});
    end
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      e = (13 - i < 0) ? 0 : 13 - i;
      n_cmp++;
      if ({a_q2, a_q1, a_busy, a_done} !== {3'(e / 10), 4'(e % 10), e != 0, i == 13}) begin
        n_fail++; $display("FAIL countdown_tick%0d: got %h expected %h", i,
                           {a_q2, a_q1, a_busy, a_done},
                           {3'(e / 10), 4'(e % 10), e != 0, i == 13});
      end
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL countdown_model%0d: got %h expected %h", i, obs(), expv());
      end
    end
    drive(0, 0, 0, 0, 1, 0, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy, a_done} !== 9'd0) begin
      n_fail++; $display("FAIL expired_ignores_start: got %h expected %h",
                         {a_q2, a_q1, a_busy, a_done}, 9'd0);
    end
  endtask

  task automatic test_clamp_full();
    int dones = 0;
    drive(0, 1, 15, 7, 0, 0, 0);
    n_cmp++;
    if ({a_q2, a_q1, b_q2, b_q1} !== {3'd6, 4'd9, 3'd6, 4'd9}) begin
      n_fail++; $display("FAIL clamp_load: got %h expected %h",
                         {a_q2, a_q1, b_q2, b_q1}, {3'd6, 4'd9, 3'd6, 4'd9});
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 69; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      if (a_done) dones++;
      if (i == 10 || i == 60) begin
        n_cmp++;
        if ({a_q2, a_q1} !== {3'((69 - i) / 10), 4'(9)}) begin
          n_fail++; $display("FAIL borrow_at_%0d: got %h expected %h", 69 - i,
                             {a_q2, a_q1}, {3'((69 - i) / 10), 4'(9)});
        end
      end
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL full_model%0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if ({a_q2, a_q1, a_busy, dones} !== {3'd0, 4'd0, 1'b0, 32'd1}) begin
      n_fail++; $display("FAIL full_expiry: q=%h busy=%0d dones=%0d expected 00/0/1",
                         {a_q2, a_q1}, a_busy, dones);
    end
  endtask

  task automatic test_pause();
    drive(0, 1, 5, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy} !== {3'd2, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL pause_pre: got %h expected %h", {a_q2, a_q1, a_busy}, {3'd2, 4'd2, 1'b1});
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy} !== {3'd2, 4'd2, 1'b0}) begin
      n_fail++; $display("FAIL pause_hold: got %h expected %h", {a_q2, a_q1, a_busy}, {3'd2, 4'd2, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy} !== {3'd2, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL pause_resume: got %h expected %h", {a_q2, a_q1, a_busy}, {3'd2, 4'd1, 1'b1});
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy} !== {3'd2, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL pause_wins: got %h expected %h", {a_q2, a_q1, a_busy}, {3'd2, 4'd1, 1'b0});
    end
    n_cmp++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL pause_model: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_load_midrun();
    drive(0, 1, 8, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 5, 0, 1, 0, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy, a_done} !== {3'd0, 4'd5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL load_midrun: got %h expected %h",
                         {a_q2, a_q1, a_busy, a_done}, {3'd0, 4'd5, 1'b0, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({a_q2, a_q1, a_busy} !== {3'd0, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL idle_ignores_tick: got %h expected %h", {a_q2, a_q1, a_busy}, {3'd0, 4'd5, 1'b0});
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (obs() !== 18'd0) begin
      n_fail++; $display("FAIL start_at_zero: got %h expected %h", obs(), 18'd0);
    end
  endtask

  task automatic test_autoreload();
    drive(0, 1, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if ({b_q2, b_q1, b_busy, b_done} !== {3'd0, 4'((i % 2 == 1) ? 1 : 2), 1'b1, i % 2 == 0}) begin
        n_fail++; $display("FAIL autoreload_tick%0d: got %h expected %h", i,
                           {b_q2, b_q1, b_busy, b_done},
                           {3'd0, 4'((i % 2 == 1) ? 1 : 2), 1'b1, i % 2 == 0});
      end
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL autoreload_model%0d: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(15) == 0,
            int'($urandom_range(15)), int'($urandom_range(7)),
            $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lu = '0; lt = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    test_reset();
    test_countdown();
    test_clamp_full();
    test_pause();
    test_load_midrun();
    test_autoreload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
